// File: rtl/vmx_sa_stream.sv
// Weight-stationary systolic matrix-vector engine: ROWS x COLS signed MAC array with
// input skew, output deskew, valid/ready streaming and per-weight-set SIMD halves.
module vmx_sa_stream #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [COLS*DATA_W-1:0]  w_data,
  input  logic                    w_simd,
  input  logic                    w_start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ROWS*DATA_W-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [COLS*ACC_W-1:0]   out_data,
  output logic                    busy
);

  localparam int LAT    = ROWS + COLS;
  localparam int CNT_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int OCC_W  = $clog2(LAT + 2) + 1;
  localparam int PROD_W = 2 * DATA_W;
  localparam int HALF_D = DATA_W / 2;
  localparam int HALF_A = ACC_W / 2;

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]             state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   simd_r;
  logic [COLS*DATA_W-1:0] w_row_r [ROWS];
  logic [OCC_W-1:0]       occ_r;
  logic [LAT:0]           vld_r;
  logic                   stall_s;
  logic                   adv_s;
  logic                   in_acc_s;
  logic                   out_acc_s;

  logic [DATA_W-1:0] a_in_s     [ROWS][COLS];
  logic [ACC_W-1:0]  p_out_s    [ROWS][COLS];
  logic [ACC_W-1:0]  col_tail_s [COLS];

  // Normal mode: one full-width product; SIMD: two independent half-lane accumulations.
  function automatic logic [ACC_W-1:0] mac(input logic [ACC_W-1:0]  p,
                                           input logic [DATA_W-1:0] a,
                                           input logic [DATA_W-1:0] w,
                                           input logic              simd);
    logic signed [DATA_W-1:0] a_f, w_f;
    logic signed [HALF_D-1:0] a_lo, a_hi, w_lo, w_hi;
    logic signed [PROD_W-1:0] prod;
    logic signed [DATA_W-1:0] prod_lo, prod_hi;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [HALF_A-1:0] lo_ext, hi_ext;
    logic [HALF_A-1:0]        sum_lo, sum_hi;
    a_f      = a;
    w_f      = w;
    a_lo     = a[HALF_D-1:0];
    a_hi     = a[DATA_W-1:HALF_D];
    w_lo     = w[HALF_D-1:0];
    w_hi     = w[DATA_W-1:HALF_D];
    prod     = PROD_W'(a_f) * PROD_W'(w_f);
    prod_lo  = DATA_W'(a_lo) * DATA_W'(w_lo);
    prod_hi  = DATA_W'(a_hi) * DATA_W'(w_hi);
    prod_ext = ACC_W'(prod);
    lo_ext   = HALF_A'(prod_lo);
    hi_ext   = HALF_A'(prod_hi);
    sum_lo   = p[HALF_A-1:0] + lo_ext;
    sum_hi   = p[ACC_W-1:HALF_A] + hi_ext;
    if (simd) begin
      return {sum_hi, sum_lo};
    end else begin
      return p + prod_ext;
    end
  endfunction

  assign out_valid = vld_r[LAT];
  assign stall_s   = out_valid && !out_ready;
  assign adv_s     = !stall_s;
  assign w_ready   = (state_r == ST_LOAD);
  assign in_ready  = (state_r == ST_RUN) && !stall_s;
  assign in_acc_s  = in_valid && in_ready;
  assign out_acc_s = out_valid && out_ready;
  assign busy      = (state_r == ST_DRAIN) || (occ_r != {OCC_W{1'b0}});

  // Weight-set lifecycle: rows are written only in LOAD, so a set never changes under traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_LOAD;
      cnt_r   <= {CNT_W{1'b0}};
      simd_r  <= 1'b0;
      for (int r = 0; r < ROWS; r++) w_row_r[r] <= {(COLS*DATA_W){1'b0}};
    end else begin
      case (state_r)
        ST_LOAD: begin
          if (w_valid) begin
            w_row_r[cnt_r] <= w_data;
            if (cnt_r == {CNT_W{1'b0}}) simd_r <= w_simd;
            if (cnt_r == CNT_W'(ROWS - 1)) begin
              state_r <= ST_RUN;
              cnt_r   <= {CNT_W{1'b0}};
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        ST_RUN: begin
          if (w_start) state_r <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (occ_r == {OCC_W{1'b0}}) begin
            state_r <= ST_LOAD;
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        default: begin
          state_r <= ST_LOAD;
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Vectors in flight: accepted but not yet handed downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_r <= {OCC_W{1'b0}};
    end else if (in_acc_s && !out_acc_s) begin
      occ_r <= occ_r + OCC_W'(1);
    end else if (!in_acc_s && out_acc_s) begin
      occ_r <= occ_r - OCC_W'(1);
    end
  end

  // Valid tokens travel alongside the data and freeze with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r <= {(LAT+1){1'b0}};
    end else if (adv_s) begin
      vld_r <= {vld_r[LAT-1:0], in_acc_s};
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    logic [DATA_W-1:0] sk_r [r+1];
    // Row r enters the array r cycles late; bubbles inject zeros.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i <= r; i++) sk_r[i] <= {DATA_W{1'b0}};
      end else if (adv_s) begin
        sk_r[0] <= in_acc_s ? in_data[r*DATA_W +: DATA_W] : {DATA_W{1'b0}};
        for (int i = 1; i <= r; i++) sk_r[i] <= sk_r[i-1];
      end
    end
    assign a_in_s[r][0] = sk_r[r];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe
      logic [ACC_W-1:0] psum_r;
      logic [ACC_W-1:0] p_in_s;
      if (r == 0) begin : g_top
        assign p_in_s = {ACC_W{1'b0}};
      end else begin : g_mid
        assign p_in_s = p_out_s[r-1][c];
      end
      // Partial sum moves down one row per cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          psum_r <= {ACC_W{1'b0}};
        end else if (adv_s) begin
          psum_r <= mac(p_in_s, a_in_s[r][c], w_row_r[r][c*DATA_W +: DATA_W], simd_r);
        end
      end
      assign p_out_s[r][c] = psum_r;
      if (c < COLS - 1) begin : g_fwd
        logic [DATA_W-1:0] a_r;
        // Activation moves right one column per cycle.
        always_ff @(posedge clk) begin
          if (rst) begin
            a_r <= {DATA_W{1'b0}};
          end else if (adv_s) begin
            a_r <= a_in_s[r][c];
          end
        end
        assign a_in_s[r][c+1] = a_r;
      end
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_desk
    localparam int D = COLS - 1 - c;
    if (D > 0) begin : g_dly
      logic [ACC_W-1:0] dk_r [D];
      // Early columns wait so every column of a vector lands together.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < D; i++) dk_r[i] <= {ACC_W{1'b0}};
        end else if (adv_s) begin
          dk_r[0] <= p_out_s[ROWS-1][c];
          for (int i = 1; i < D; i++) dk_r[i] <= dk_r[i-1];
        end
      end
      assign col_tail_s[c] = dk_r[D-1];
    end else begin : g_thru
      assign col_tail_s[c] = p_out_s[ROWS-1][c];
    end
  end

  // Output register holds still whenever downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= {(COLS*ACC_W){1'b0}};
    end else if (adv_s) begin
      for (int c = 0; c < COLS; c++) out_data[c*ACC_W +: ACC_W] <= col_tail_s[c];
    end
  end

endmodule

// File: tb/tb_vmx_sa_stream.sv
// Randomised self-checking bench for vmx_sa_stream against a plain dot-product model.
module tb_vmx_sa_stream;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 16;
  localparam int AW   = 40;
  localparam int XW   = ROWS * DW;
  localparam int OW   = COLS * AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          w_valid, w_ready, w_simd, w_start;
  logic [XW-1:0] w_data;
  logic          in_valid, in_ready;
  logic [XW-1:0] in_data;
  logic          out_valid, out_ready;
  logic [OW-1:0] out_data;
  logic          busy;

  vmx_sa_stream #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_simd(w_simd), .w_start(w_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int            compared = 0;
  int            mismatched = 0;
  logic [XW-1:0] act_w [ROWS];
  logic          act_simd = 1'b0;
  logic [OW-1:0] exp_q [$];
  logic [OW-1:0] got_q [$];
  logic          smp_valid = 1'b0;
  logic          smp_stall = 1'b0;
  logic [OW-1:0] smp_data = '0;

  // out[c] = sum_r x[r]*W[r][c], computed with wide integers then truncated.
  function automatic logic [OW-1:0] model(input logic [XW-1:0] x);
    logic [OW-1:0]    res;
    longint           s, sl, sh;
    logic signed [15:0] xs, ws;
    logic signed [7:0]  xl, xh, wl, wh;
    res = '0;
    for (int c = 0; c < COLS; c++) begin
      s = 0; sl = 0; sh = 0;
      for (int r = 0; r < ROWS; r++) begin
        xs = x[r*DW +: DW];
        ws = act_w[r][c*DW +: DW];
        xl = xs[7:0]; xh = xs[15:8];
        wl = ws[7:0]; wh = ws[15:8];
        s  = s  + longint'(xs) * longint'(ws);
        sl = sl + longint'(xl) * longint'(wl);
        sh = sh + longint'(xh) * longint'(wh);
      end
      if (act_simd) res[c*AW +: AW] = {sh[19:0], sl[19:0]};
      else          res[c*AW +: AW] = s[39:0];
    end
    return res;
  endfunction

  function automatic logic [XW-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  task automatic tick();
    @(negedge clk);
    smp_valid = out_valid;
    smp_stall = out_valid && !out_ready;
    smp_data  = out_data;
    if (in_valid && in_ready) exp_q.push_back(model(in_data));
    if (out_valid && out_ready) got_q.push_back(out_data);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_results(input int n);
    int g = 0;
    while (got_q.size() < n && g < 300) begin tick(); g++; end
  endtask

  task automatic load_weights(input logic [XW-1:0] rows [ROWS], input logic simd);
    int g = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (!w_ready) begin
      w_start = 1'b1; tick(); w_start = 1'b0;
    end
    while (!w_ready && g < 200) begin tick(); g++; end
    compared++;
    if (w_ready !== 1'b1) begin
      mismatched++; $display("FAIL load_wait: w_ready=%b required 1", w_ready);
    end
    for (int r = 0; r < ROWS; r++) begin
      w_valid = 1'b1; w_data = rows[r];
      w_simd  = (r == 0) ? simd : ~simd;
      tick();
    end
    w_valid = 1'b0; w_simd = 1'b0;
    act_w = rows; act_simd = simd;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; w_valid = 1'b0; w_simd = 1'b0; w_start = 1'b0; w_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    compared += 5;
    if (w_ready !== 1'b1)  begin mismatched++; $display("FAIL rst_w_ready: got %b required 1", w_ready); end
    if (in_ready !== 1'b0) begin mismatched++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    if (out_data !== '0)   begin mismatched++; $display("FAIL rst_out_data: got %h required 0", out_data); end
    if (busy !== 1'b0)     begin mismatched++; $display("FAIL rst_busy: got %b required 0", busy); end
  endtask

  task automatic test_identity();
    logic [XW-1:0] rows [ROWS];
    logic [OW-1:0] want;
    int lat = 0;
    for (int r = 0; r < ROWS; r++) rows[r] = XW'(1) << (r * DW);
    load_weights(rows, 1'b0);
    in_data = {16'd4, 16'd3, 16'd2, 16'd1}; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("FAIL id_busy: got %b required 1", busy); end
    while (out_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    want = {40'd4, 40'd3, 40'd2, 40'd1};
    compared += 2;
    if (lat != 8) begin mismatched++; $display("FAIL id_latency: got %0d required 8", lat); end
    if (out_data !== want) begin mismatched++; $display("FAIL id_data: got %h required %h", out_data, want); end
    tick();
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL id_busy_end: got %b required 0", busy); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_fullscale();
    logic [XW-1:0] rows [ROWS];
    logic [OW-1:0] want;
    for (int r = 0; r < ROWS; r++) rows[r] = {4{16'h8000}};
    load_weights(rows, 1'b0);
    in_data = {4{16'h8000}}; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_results(1);
    want = {4{40'h01_0000_0000}};
    compared++;
    if (got_q.size() != 1 || got_q[0] !== want) begin
      mismatched++; $display("FAIL fullscale: got %h (n=%0d) required %h", got_q.size() > 0 ? got_q[0] : '0, got_q.size(), want);
    end
  endtask

  task automatic test_simd();
    logic [XW-1:0] rows [ROWS];
    logic [OW-1:0] want;
    for (int r = 0; r < ROWS; r++) rows[r] = {4{16'hFF02}};
    load_weights(rows, 1'b1);
    in_data = {4{16'h03FC}}; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_results(1);
    want = {4{20'hFFFF4, 20'hFFFE0}};
    compared++;
    if (got_q.size() != 1 || got_q[0] !== want) begin
      mismatched++; $display("FAIL simd: got %h (n=%0d) required %h", got_q.size() > 0 ? got_q[0] : '0, got_q.size(), want);
    end
  endtask

  task automatic test_random_simd();
    logic [XW-1:0] rows [ROWS];
    for (int r = 0; r < ROWS; r++) rows[r] = rnd();
    load_weights(rows, 1'b1);
    for (int i = 0; i < 8; i++) begin in_valid = 1'b1; in_data = rnd(); tick(); end
    in_valid = 1'b0;
    wait_results(8);
    compared++;
    if (got_q.size() != 8) begin mismatched++; $display("FAIL rsimd_count: got %0d required 8", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      compared++;
      if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL rsimd_%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [XW-1:0] rows [ROWS];
    logic          prev_stall;
    logic [OW-1:0] prev_data;
    int g = 0;
    int n_before;
    for (int r = 0; r < ROWS; r++) rows[r] = rnd();
    load_weights(rows, 1'b0);
    in_valid = 1'b1; in_data = rnd();
    while (got_q.size() < 10 && g < 400) begin
      out_ready  = 1'($urandom_range(0, 1));
      prev_stall = smp_stall;
      prev_data  = smp_data;
      n_before   = exp_q.size();
      tick();
      if (prev_stall) begin
        compared++;
        if (smp_data !== prev_data || smp_valid !== 1'b1) begin
          mismatched++; $display("FAIL stall_hold: got %h v=%b required %h v=1", smp_data, smp_valid, prev_data);
        end
      end
      if (exp_q.size() >= 10) in_valid = 1'b0;
      else if (exp_q.size() != n_before) in_data = rnd();
      g++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    compared++;
    if (got_q.size() != 10 || exp_q.size() != 10) begin
      mismatched++; $display("FAIL b2b_count: got %0d/%0d required 10/10", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      compared++;
      if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL b2b_%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reload();
    logic [XW-1:0] rows [ROWS];
    int g = 0;
    for (int r = 0; r < ROWS; r++) rows[r] = rnd();
    load_weights(rows, 1'b0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = rnd();
      w_start  = (i == 2);
      tick();
    end
    w_start = 1'b0; in_data = rnd();
    compared++;
    if (in_ready !== 1'b0) begin mismatched++; $display("FAIL reload_in_ready: got %b required 0", in_ready); end
    while (busy === 1'b1 && g < 100) begin tick(); g++; end
    in_valid = 1'b0;
    compared += 3;
    if (busy !== 1'b0)    begin mismatched++; $display("FAIL reload_busy: got %b required 0", busy); end
    if (w_ready !== 1'b1) begin mismatched++; $display("FAIL reload_w_ready: got %b required 1", w_ready); end
    if (got_q.size() != 3 || exp_q.size() != 3) begin
      mismatched++; $display("FAIL reload_count: got %0d/%0d required 3/3", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      compared++;
      if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL reload_old_%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
    for (int r = 0; r < ROWS; r++) rows[r] = rnd();
    load_weights(rows, 1'b0);
    for (int i = 0; i < 4; i++) begin in_valid = 1'b1; in_data = rnd(); tick(); end
    in_valid = 1'b0;
    wait_results(4);
    compared++;
    if (got_q.size() != 4) begin mismatched++; $display("FAIL reload_new_count: got %0d required 4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      compared++;
      if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL reload_new_%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midstream();
    logic any_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin in_valid = 1'b1; in_data = rnd(); tick(); end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete(); got_q.delete();
    compared += 4;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL mid_rst_out_valid: got %b required 0", out_valid); end
    if (w_ready !== 1'b1)   begin mismatched++; $display("FAIL mid_rst_w_ready: got %b required 1", w_ready); end
    if (in_ready !== 1'b0)  begin mismatched++; $display("FAIL mid_rst_in_ready: got %b required 0", in_ready); end
    if (busy !== 1'b0)      begin mismatched++; $display("FAIL mid_rst_busy: got %b required 0", busy); end
    in_valid = 1'b1; in_data = rnd();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (smp_valid) any_valid = 1'b1;
    end
    in_valid = 1'b0;
    compared += 2;
    if (any_valid !== 1'b0) begin mismatched++; $display("FAIL mid_rst_ghost: got out_valid=1 required 0"); end
    if (exp_q.size() != 0) begin mismatched++; $display("FAIL mid_rst_accept: got %0d accepts required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_fullscale();
    test_simd();
    test_random_simd();
    test_back_to_back();
    test_reload();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vmx_sa_stream.md
# vmx_sa_stream

Weight-stationary systolic matrix-vector engine, ROWS×COLS signed multiply-accumulate array with internal input skew, output deskew, valid/ready streaming and per-weight-set SIMD mode. It is the parametrised successor to the fixed 4×4 VMX PE array: rectangular, wider accumulators, stallable pipeline and a managed weight-load phase. It sits between the AXI-stream activation feeder and the result writer in the VMX datapath.

## Interface
- ROWS, 4, array rows = activation vector length (≥1)
- COLS, 4, array columns = result vector length (≥1)
- DATA_W, 16, activation/weight lane width, even
- ACC_W, 40, accumulator width per column, even, ≥ 2*DATA_W
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- w_valid  in  1  weight row beat valid
- w_ready  out  1  weight beat accepted when w_valid && w_ready
- w_data  in  COLS*DATA_W  one weight row, column c at [c*DATA_W +: DATA_W]
- w_simd  in  1  SIMD mode, sampled on first weight beat of a set
- w_start  in  1  pulse: request new weight set
- in_valid  in  1  activation vector valid
- in_ready  out  1  activation accepted when in_valid && in_ready
- in_data  in  ROWS*DATA_W  activation, row r at [r*DATA_W +: DATA_W]
- out_valid  out  1  result vector valid
- out_ready  in  1  downstream accepts
- out_data  out  COLS*ACC_W  result, column c at [c*ACC_W +: ACC_W]
- busy  out  1  high in DRAIN or while any vector in flight

## Operation
- States: LOAD, RUN, DRAIN. Reset → LOAD, row counter 0, all weights 0, simd 0, occupancy 0.
- LOAD: w_ready=1, in_ready=0. Each accepted beat writes row[cnt], cnt++. Beat with cnt=ROWS-1 → RUN, cnt←0. w_simd latched on beat cnt=0. w_start ignored in LOAD.
- RUN: w_ready=0; in_ready = !stall. w_start → DRAIN (in_ready=0 from the following cycle); w_start on same cycle as an accepted input: input is accepted.
- DRAIN: in_ready=0, w_ready=0; when occupancy reaches 0 (last result handshaken) → LOAD, cnt←0. Weights are not altered until LOAD beats arrive.
- Result: out[c] = Σ_r x[r]·W[r][c].
- Normal mode: operands signed DATA_W, products signed 2*DATA_W, sign-extended to ACC_W, sum wraps mod 2^ACC_W.
- SIMD mode: each DATA_W lane splits into signed halves lo=[DATA_W/2-1:0], hi=[DATA_W-1:DATA_W/2]; lo·lo and hi·hi accumulate independently in ACC_W/2 lanes, packed {hi,lo} in each column; each half wraps mod 2^(ACC_W/2), no carry between halves.
- Dataflow: row r activations delayed r cycles (skew regs), pass right through PEs; partial sums pass down; column c output delayed COLS-1-c cycles (deskew regs) so all columns align.
- Occupancy counter: +1 on input accept, −1 on output accept, both in same cycle = unchanged.

## Timing
- Stall = out_valid && !out_ready. Stall freezes all pipeline, skew, deskew registers and valid tokens; out_data held stable while stalled.
- Latency L = ROWS + COLS cycles: vector accepted on edge t → out_valid at edge t+L with no stall; each stalled cycle adds one.
- Throughput: one vector/cycle when out_ready=1.
- Weight set applies to vectors accepted after entering RUN; no vector ever mixes two weight sets.
- Reset values: w_ready=1, in_ready=0, out_valid=0, out_data=0, busy=0.
- Reset mid-operation: all in-flight vectors discarded, no out_valid after reset deasserts until new LOAD and input.
- in_valid with in_ready=0 has no effect; out_valid never drops without out_ready.

## Test plan
- Identity: ROWS=COLS=4, W=I, x={1,2,3,4} → out={1,2,3,4} exactly 8 cycles after accept.
- Full-scale signed: W all 0x8000, x all 0x8000, ROWS=4 → each column 4·2^30 = 0x01_0000_0000; ACC_W=32 variant wraps to 0.
- SIMD: w_simd=1, W lanes {hi=-1,lo=2}, x {hi=3,lo=-4}, ROWS=4 → per column hi=-12, lo=-32 packed.
- Backpressure: 10 back-to-back vectors, out_ready toggled 1-0-0-1 random → all 10 results in order, none dropped or duplicated, out_data stable during stall.
- Reload mid-stream: w_start after 3 inputs → in_ready low next cycle, 3 results with old weights, busy falls, w_ready rises, new set used for subsequent vectors.
- Reset mid-stream with 5 in flight → out_valid=0, w_ready=1, state LOAD, weights zero next cycle.
